// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_out,
  input  logic [31:0] rs2_out,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;
  logic        signA_q, signA_d;
  logic        signB_q, signB_d;
  logic [31:0] result_q, result_d;

  logic        signedA, signedB, negA, negB;
  logic [31:0] magA, magB;
  logic        divZero, divOvf;
  logic [31:0] fastResult;

  // Operand signedness and magnitudes of the incoming op
  assign signedA = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
  assign signedB = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign negA    = signedA && rs1_out[31];
  assign negB    = signedB && rs2_out[31];
  assign magA    = negA ? (~rs1_out + 32'd1) : rs1_out;
  assign magB    = negB ? (~rs2_out + 32'd1) : rs2_out;

  assign divZero    = funct3[2] && (rs2_out == 32'd0);
  assign divOvf     = funct3[2] && !funct3[0] && (rs1_out == 32'h8000_0000) && (rs2_out == 32'hFFFF_FFFF);
  assign fastResult = divZero ? (funct3[1] ? rs1_out : 32'hFFFF_FFFF)
                              : (funct3[1] ? 32'd0 : 32'h8000_0000);

  logic [32:0] mulSum, divShift, divDiff;
  logic        divFits;
  logic [31:0] stepHi, stepLo;
  logic [63:0] prodMag, prodSigned;
  logic [31:0] quoSigned, remSigned, finalResult;

  // A borrow out of the trial subtraction means the divisor does not fit
  always_comb begin
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    divShift = {hi_q, lo_q[31]};
    divDiff  = divShift - {1'b0, b_q};
    divFits  = ~divDiff[32];
    if (op_q[2]) begin
      stepHi = divFits ? divDiff[31:0] : divShift[31:0];
      stepLo = {lo_q[30:0], divFits};
    end else begin
      stepHi = mulSum[32:1];
      stepLo = {mulSum[0], lo_q[31:1]};
    end
  end

  always_comb begin
    prodMag    = {stepHi, stepLo};
    prodSigned = (signA_q ^ signB_q) ? (~prodMag + 64'd1) : prodMag;
    quoSigned  = (signA_q ^ signB_q) ? (~stepLo + 32'd1) : stepLo;
    remSigned  = signA_q ? (~stepHi + 32'd1) : stepHi;
    case (op_q)
      3'd0:          finalResult = prodSigned[31:0];
      3'd1, 3'd2, 3'd3: finalResult = prodSigned[63:32];
      3'd4, 3'd5:    finalResult = quoSigned;
      default:       finalResult = remSigned;
    endcase
  end

  // Flush wins over both a new start and the final COMPUTE step
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    signA_d  = signA_q;
    signB_d  = signB_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d    = funct3;
            signA_d = negA;
            signB_d = negB;
            hi_d    = 32'd0;
            lo_d    = magA;
            b_d     = magB;
            cnt_d   = 6'd0;
            if (divZero || divOvf) begin
              result_d = fastResult;
              state_d  = DONE;
            end else begin
              state_d = COMPUTE;
            end
          end
        end
        COMPUTE: begin
          hi_d  = stepHi;
          lo_d  = stepLo;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_d = finalResult;
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      b_q      <= 32'd0;
      signA_q  <= 1'b0;
      signB_q  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      signA_q  <= signA_d;
      signB_q  <= signB_d;
      result_q <= result_d;
    end
  end

  assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == COMPUTE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model checked every
// cycle, directed literal cases, flush/reset scenarios and randomized traffic.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_out, rs2_out;
  logic        stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .flush(flush),
    .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural result of an RV32M op using plain 64-bit arithmetic
  function automatic logic [31:0] refOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic bit isSpecial(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Latency-level model: cycles left in the iterative phase, and the held result
  int          mLeft = 0;
  bit          mInDone = 0;
  logic [31:0] mLast = 32'd0;
  logic [31:0] mPend = 32'd0;
  bit          checkEn = 0;

  always @(posedge clk) begin
    if (rst) begin
      mLeft = 0; mInDone = 0; mLast = 32'd0;
    end else if (flush) begin
      mLeft = 0; mInDone = 0;
    end else if (mInDone) begin
      mInDone = 0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) begin mInDone = 1; mLast = mPend; end
    end else if (start) begin
      mPend = refOp(funct3, rs1_out, rs2_out);
      if (isSpecial(funct3, rs1_out, rs2_out)) begin mInDone = 1; mLast = mPend; end
      else mLeft = 32;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall", 32'(stall), 32'((mLeft == 0 && !mInDone && start && !flush) || (mLeft > 0)));
      checkOutput("done", 32'(done), 32'(mInDone));
      checkOutput("result", result, mLast);
    end
  end

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input int expCyc, input string name);
    int cyc;
    bit seen;
    funct3 = f; rs1_out = a; rs2_out = b; start = 1'b1;
    #1 checkOutput({name, "_stall0"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); rs1_out = $urandom; rs2_out = $urandom;
    cyc = 1; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    checkOutput({name, "_cycle"}, 32'(cyc), 32'(expCyc));
    checkOutput({name, "_result"}, result, expRes);
    checkOutput({name, "_stallDone"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, firstDone, secondDone;
    bit sawDone;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; rs1_out = 32'd0; rs2_out = 32'd0;
    repeat (2) @(posedge clk);
    #1 checkEn = 1;
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
    applyStimulus(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    applyStimulus(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");
    applyStimulus(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu0");
    applyStimulus(3'd7, 32'd5, 32'd0, 32'd5, 1, "remu0");
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "divOvf");
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "remOvf");

    // Flush during cycle 10 of a DIV, then a fresh MUL in cycle 11
    funct3 = 3'd4; rs1_out = 32'd1000; rs2_out = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    checkOutput("flush_stall", 32'(stall), 32'd0);
    checkOutput("flush_done", 32'(done), 32'd0);
    applyStimulus(3'd0, 32'd3, 32'd4, 32'd12, 33, "postFlushMul");

    // Reset during cycle 20 of a MUL abandons it
    funct3 = 3'd0; rs1_out = 32'd5; rs2_out = 32'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checkOutput("rstMid_stall", 32'(stall), 32'd0);
    checkOutput("rstMid_done", 32'(done), 32'd0);
    checkOutput("rstMid_result", result, 32'd0);
    sawDone = 0;
    repeat (40) begin @(negedge clk); if (done) sawDone = 1; end
    checkOutput("rstMid_noDone", 32'(sawDone), 32'd0);
    @(posedge clk); #1;

    // Two back-to-back MULs with start held high
    funct3 = 3'd0; rs1_out = 32'h0001_2345; rs2_out = 32'h0000_0777; start = 1'b1;
    firstDone = -1; secondDone = -1;
    for (cyc = 0; cyc < 70; cyc++) begin
      if (cyc == 67) start = 1'b0;
      @(negedge clk);
      if (done) begin
        if (firstDone < 0) firstDone = cyc;
        else if (secondDone < 0) secondDone = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("b2b_firstDone", 32'(firstDone), 32'd33);
    checkOutput("b2b_secondDone", 32'(secondDone), 32'd67);
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic, including flushes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 80) == 0);
      rst     = ($urandom_range(0, 400) == 0);
      funct3  = 3'($urandom_range(0, 7));
      rs1_out = randOperand();
      rs2_out = randOperand();
      @(posedge clk); #1;
    end
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    #1 checkEn = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
